hazard_scoreboard_unit: RTL

//  Next-generation ID-stage hazard/forwarding controller for the 5-stage RISC-V pipeline.

---
 rtl/hazard_scoreboard_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hazard_scoreboard_unit                                           |
// | Desc    : ID-stage stall/flush/forward control with EX/MEM destination     |
// |           shadows and a countdown scoreboard for one multi-cycle unit.     |
// |           Optional stall counter: define HAZARD_PERF_CNT_EN.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hazard_scoreboard_unit #(
   parameter int REG_AW     = 5,
   parameter int MC_LAT_MAX = 16,
   parameter int FWD_W      = 3,
   localparam int LAT_W     = $clog2(MC_LAT_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Branch_ID,
   input  logic              rs1use_ID,
   input  logic              rs2use_ID,
   input  logic              rdwrite_ID,
   input  logic [2:0]        optype_ID,
   input  logic [REG_AW-1:0] rs1_ID,
   input  logic [REG_AW-1:0] rs2_ID,
   input  logic [REG_AW-1:0] rd_ID,
   input  logic [LAT_W-1:0]  mc_lat_ID,
   output logic              PC_EN_IF,
   output logic              reg_FD_EN,
   output logic              reg_DE_EN,
   output logic              reg_EM_EN,
   output logic              reg_MW_EN,
   output logic              reg_FD_stall,
   output logic              reg_FD_flush,
   output logic              reg_DE_flush,
   output logic              reg_EM_flush,
   output logic [FWD_W-1:0]  forward_ctrl_A,
   output logic [FWD_W-1:0]  forward_ctrl_B,
   output logic              forward_ctrl_ls,
   output logic              mc_done,
   output logic [31:0]       stall_cnt
);

   localparam logic [2:0] c_OP_NORMAL = 3'd0;
   localparam logic [2:0] c_OP_ALU    = 3'd1;
   localparam logic [2:0] c_OP_STORE  = 3'd2;
   localparam logic [2:0] c_OP_LOAD   = 3'd3;
   localparam logic [2:0] c_OP_MC     = 3'd4;

   localparam logic [FWD_W-1:0] c_FWD_RF     = FWD_W'(0);
   localparam logic [FWD_W-1:0] c_FWD_EX_ALU = FWD_W'(1);
   localparam logic [FWD_W-1:0] c_FWD_ME_ALU = FWD_W'(2);
   localparam logic [FWD_W-1:0] c_FWD_ME_LD  = FWD_W'(3);
   localparam logic [FWD_W-1:0] c_FWD_MC     = FWD_W'(4);

   // In-flight destination shadows for the instructions now in EX and MEM
   logic [REG_AW-1:0] r_rd_ex;
   logic [2:0]        r_op_ex;
   logic [REG_AW-1:0] r_rs2_ex;
   logic [REG_AW-1:0] r_rd_me;
   logic [2:0]        r_op_me;

   logic [LAT_W-1:0]  r_mc_cnt;
   logic [REG_AW-1:0] r_mc_rd;

   logic              w_mc_busy;
   logic              w_mc_done;
   logic              w_mc_block;
   logic              w_ld_use_rs1;
   logic              w_ld_use_rs2;
   logic              w_mc_raw;
   logic              w_mc_waw;
   logic              w_mc_struct;
   logic              w_stall;
   logic              w_mc_issue;
   logic [LAT_W-1:0]  w_mc_lat_eff;
   logic [REG_AW-1:0] w_rd_id_eff;

   assign w_mc_busy  = (r_mc_cnt != '0);
   assign w_mc_done  = (r_mc_cnt == LAT_W'(1));
   assign w_mc_block = w_mc_busy && !w_mc_done;

   assign w_rd_id_eff  = rdwrite_ID ? rd_ID : '0;
   assign w_mc_lat_eff = (mc_lat_ID == '0) ? LAT_W'(1) : mc_lat_ID;

   // Load result is not ready until MEM; a store's data operand is instead
   // patched in EX through forward_ctrl_ls.
   assign w_ld_use_rs1 = (r_op_ex == c_OP_LOAD) && (r_rd_ex != '0) &&
                         rs1use_ID && (rs1_ID == r_rd_ex);
   assign w_ld_use_rs2 = (r_op_ex == c_OP_LOAD) && (r_rd_ex != '0) &&
                         rs2use_ID && (rs2_ID == r_rd_ex) &&
                         (optype_ID != c_OP_STORE);

   assign w_mc_raw    = w_mc_block && (r_mc_rd != '0) &&
                        ((rs1use_ID && (rs1_ID == r_mc_rd)) ||
                         (rs2use_ID && (rs2_ID == r_mc_rd)));
   assign w_mc_waw    = w_mc_block && (r_mc_rd != '0) && rdwrite_ID &&
                        (rd_ID == r_mc_rd);
   assign w_mc_struct = w_mc_block && (optype_ID == c_OP_MC);

   assign w_stall    = w_ld_use_rs1 || w_ld_use_rs2 || w_mc_raw || w_mc_waw || w_mc_struct;
   assign w_mc_issue = (optype_ID == c_OP_MC) && !w_stall;

   function automatic logic [FWD_W-1:0] fwd_sel(input logic used,
                                                input logic [REG_AW-1:0] rs);
      logic [FWD_W-1:0] sel;
      sel = c_FWD_RF;
      if (used && (rs != '0)) begin
         if ((r_op_ex == c_OP_ALU) && (r_rd_ex == rs))
            sel = c_FWD_EX_ALU;
         else if ((r_op_me == c_OP_ALU) && (r_rd_me == rs))
            sel = c_FWD_ME_ALU;
         else if ((r_op_me == c_OP_LOAD) && (r_rd_me == rs))
            sel = c_FWD_ME_LD;
         else if (w_mc_done && (r_mc_rd == rs))
            sel = c_FWD_MC;
      end
      return sel;
   endfunction

   always_comb begin
      forward_ctrl_A = fwd_sel(rs1use_ID, rs1_ID);
      forward_ctrl_B = fwd_sel(rs2use_ID, rs2_ID);
   end

   assign forward_ctrl_ls = (r_op_ex == c_OP_STORE) && (r_op_me == c_OP_LOAD) &&
                            (r_rd_me != '0) && (r_rs2_ex == r_rd_me);

   assign PC_EN_IF     = !w_stall;
   assign reg_FD_stall = w_stall;
   assign reg_DE_flush = w_stall;
   assign reg_FD_flush = Branch_ID && !w_stall;
   assign reg_FD_EN    = 1'b1;
   assign reg_DE_EN    = 1'b1;
   assign reg_EM_EN    = 1'b1;
   assign reg_MW_EN    = 1'b1;
   assign reg_EM_flush = 1'b0;
   assign mc_done      = w_mc_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ex  <= '0;
         r_op_ex  <= c_OP_NORMAL;
         r_rs2_ex <= '0;
         r_rd_me  <= '0;
         r_op_me  <= c_OP_NORMAL;
      end else begin
         if (w_stall) begin
            r_rd_ex  <= '0;
            r_op_ex  <= c_OP_NORMAL;
            r_rs2_ex <= '0;
         end else begin
            r_rd_ex  <= w_rd_id_eff;
            r_op_ex  <= optype_ID;
            r_rs2_ex <= rs2_ID;
         end
         r_rd_me <= r_rd_ex;
         r_op_me <= r_op_ex;
      end
   end

   // A new issue in the done cycle reloads the counter instead of letting it expire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mc_cnt <= '0;
         r_mc_rd  <= '0;
      end else if (w_mc_issue) begin
         r_mc_cnt <= w_mc_lat_eff;
         r_mc_rd  <= w_rd_id_eff;
      end else if (w_mc_busy) begin
         r_mc_cnt <= r_mc_cnt - LAT_W'(1);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
